mul_pipe_ctrl: RTL and testbench

Pipeline controller for the two-stage multiplier: M1 is Booth encoding plus the first Wallace layers, M2 is the remaining Wallace layers plus the final adder. It accepts multiply requests from the EX stage with a valid/ready handshake and tracks the valid bit, opcode and destination tag of each stage. It drives the M1→M2 advance handshake (`M1_ready_go`, `M1_out_ready`) into every Wallace slice and presents results to writeback under backpressure. It also handles flush and keeps completion and stall counters.

---
 rtl/mul_pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_mul_pipe_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pipe_ctrl
//  Purpose  : Pipeline controller for the two-stage multiplier (M1: Booth
//             encoding + first Wallace layers, M2: remaining Wallace layers +
//             final adder). Tracks valid/op/tag per stage, drives the M1->M2
//             advance handshake into the Wallace slices, presents results to
//             writeback under backpressure, handles flush and keeps
//             completion/stall counters.
//  Ports    : mul_clk, reset           clock, synchronous active-high reset
//             req_valid/req_ready      EX request handshake (req_op, req_tag)
//             flush                    cancel all in-flight ops
//             op_we, m1_signed         M1 operand load / Booth sign control
//             M1_ready_go,M1_out_ready M1->M2 advance handshake to slices
//             res_valid/res_ready      writeback handshake (res_sel_hi,
//                                      res_tag)
//             busy, done_cnt, stall_cnt  status and performance counters
//  Revision : 1.0  initial release
// ============================================================================
module mul_pipe_ctrl #(
   parameter int TAG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             mul_clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             op_we,
   output logic             m1_signed,
   output logic             M1_ready_go,
   output logic             M1_out_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_sel_hi,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   // State is the pair {m1_valid, m2_valid}.
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_M2    = 2'b01;
   localparam logic [1:0] ST_M1    = 2'b10;
   localparam logic [1:0] ST_FULL  = 2'b11;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b10;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [1:0]       m1_op_q, m2_op_q;
   logic [TAG_W-1:0] m1_tag_q, m2_tag_q;
   logic [CNT_W-1:0] done_cnt_q, stall_cnt_q;

   logic             m1_valid, m2_valid;
   logic             adv, acc, handoff, stalled;
   logic [1:0]       req_op_norm;

   assign m1_valid = state_q[1];
   assign m2_valid = state_q[0];

   assign M1_ready_go  = m1_valid & ~flush;
   assign M1_out_ready = ~m2_valid | res_ready;
   assign adv          = M1_ready_go & M1_out_ready;
   // req_ready depends only on state, flush and res_ready, never on req_valid.
   assign req_ready    = ~flush & (~m1_valid | adv);
   assign acc          = req_valid & req_ready;
   assign op_we        = acc;

   // Handoff and stall are counted even in a flush cycle.
   assign handoff      = m2_valid & res_ready;
   assign stalled      = m2_valid & ~res_ready;

   // Reserved op 11 behaves as mul.w, so normalise it on capture.
   assign req_op_norm  = (req_op == 2'b11) ? OP_MUL : req_op;

   assign res_valid    = m2_valid;
   assign res_sel_hi   = (m2_op_q != OP_MUL);
   assign res_tag      = m2_tag_q;
   assign m1_signed    = (m1_op_q != OP_MULHU);
   assign busy         = (state_q != ST_EMPTY);
   assign done_cnt     = done_cnt_q;
   assign stall_cnt    = stall_cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: state_d = acc ? ST_M1 : ST_EMPTY;
         // With M2 empty, M1 always advances when not flushed.
         ST_M1:    state_d = acc ? ST_FULL : ST_M2;
         ST_M2: begin
            if (handoff) state_d = acc ? ST_M1 : ST_EMPTY;
            else         state_d = acc ? ST_FULL : ST_M2;
         end
         // Acceptance implies advance here, so a drained+refilled FULL
         // stays FULL without a bubble.
         ST_FULL: begin
            if (adv) state_d = acc ? ST_FULL : ST_M2;
            else     state_d = ST_FULL;
         end
         default:  state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
   end

   always_ff @(posedge mul_clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         m1_op_q     <= 2'b00;
         m1_tag_q    <= '0;
         m2_op_q     <= 2'b00;
         m2_tag_q    <= '0;
         done_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (acc) begin
            m1_op_q  <= req_op_norm;
            m1_tag_q <= req_tag;
         end
         if (adv) begin
            m2_op_q  <= m1_op_q;
            m2_tag_q <= m1_tag_q;
         end
         if (handoff) done_cnt_q  <= done_cnt_q + CNT_ONE;
         if (stalled) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_pipe_ctrl
//  Purpose  : Directed self-checking bench for mul_pipe_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_pipe_ctrl;

   localparam int TAG_W = 5;
   localparam int CNT_W = 32;

   logic             mul_clk = 1'b0;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [TAG_W-1:0] req_tag;
   logic             flush;
   logic             op_we;
   logic             m1_signed;
   logic             M1_ready_go;
   logic             M1_out_ready;
   logic             res_valid;
   logic             res_ready;
   logic             res_sel_hi;
   logic [TAG_W-1:0] res_tag;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;
   logic [CNT_W-1:0] stall_cnt;

   int total = 0;
   int bad   = 0;
   int exp_done  = 0;
   int exp_stall = 0;

   mul_pipe_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .mul_clk      (mul_clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_tag      (req_tag),
      .flush        (flush),
      .op_we        (op_we),
      .m1_signed    (m1_signed),
      .M1_ready_go  (M1_ready_go),
      .M1_out_ready (M1_out_ready),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_sel_hi   (res_sel_hi),
      .res_tag      (res_tag),
      .busy         (busy),
      .done_cnt     (done_cnt),
      .stall_cnt    (stall_cnt)
   );

   always #5 mul_clk = ~mul_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge mul_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input logic rr, input logic fl);
      req_valid = v;
      req_op    = op;
      req_tag   = tag;
      res_ready = rr;
      flush     = fl;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1)    begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
      total++; if (res_valid !== 1'b0)    begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
      total++; if (M1_ready_go !== 1'b0)  begin bad++; $display("FAIL rst_m1_ready_go got=%b exp=0", M1_ready_go); end
      total++; if (M1_out_ready !== 1'b1) begin bad++; $display("FAIL rst_m1_out_ready got=%b exp=1", M1_out_ready); end
      total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (op_we !== 1'b0)        begin bad++; $display("FAIL rst_op_we got=%b exp=0", op_we); end
      total++; if (m1_signed !== 1'b1)    begin bad++; $display("FAIL rst_m1_signed got=%b exp=1", m1_signed); end
      total++; if (res_sel_hi !== 1'b0)   begin bad++; $display("FAIL rst_sel_hi got=%b exp=0", res_sel_hi); end
      total++; if (res_tag !== 5'd0)      begin bad++; $display("FAIL rst_res_tag got=%0d exp=0", res_tag); end
      total++; if (done_cnt !== 32'd0)    begin bad++; $display("FAIL rst_done_cnt got=%0d exp=0", done_cnt); end
      total++; if (stall_cnt !== 32'd0)   begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
      exp_done  = 0;
      exp_stall = 0;
   endtask

   task automatic test_back_to_back();
      logic [1:0]       ops  [4];
      logic [TAG_W-1:0] tags [4];
      logic             sels [4];
      ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b10; ops[3] = 2'b00;
      tags[0] = 5'd1; tags[1] = 5'd2; tags[2] = 5'd3; tags[3] = 5'd4;
      sels[0] = 1'b0; sels[1] = 1'b1; sels[2] = 1'b1; sels[3] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c < 4) drive(1'b1, ops[c], tags[c], 1'b1, 1'b0);
         else       drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
         if (c < 4) begin
            total++; if (op_we !== 1'b1) begin bad++; $display("FAIL b2b_op_we c=%0d got=%b exp=1", c, op_we); end
         end
         total++;
         if (res_valid !== (c >= 2)) begin
            bad++; $display("FAIL b2b_res_valid c=%0d got=%b exp=%b", c, res_valid, (c >= 2));
         end
         if (c >= 2) begin
            total++; if (res_tag !== tags[c-2]) begin bad++; $display("FAIL b2b_res_tag c=%0d got=%0d exp=%0d", c, res_tag, tags[c-2]); end
            total++; if (res_sel_hi !== sels[c-2]) begin bad++; $display("FAIL b2b_sel_hi c=%0d got=%b exp=%b", c, res_sel_hi, sels[c-2]); end
         end
         tick();
      end
      exp_done += 4;
      #1;
      total++; if (done_cnt !== 32'(exp_done))   begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=%0d", done_cnt, exp_done); end
      total++; if (stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL b2b_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", busy); end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 2'b01, 5'd8, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b00, 5'd9, 1'b0, 1'b0);
      total++; if (op_we !== 1'b1) begin bad++; $display("FAIL bp_fill_accept got=%b exp=1", op_we); end
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 2'b00, 5'd10, 1'b0, 1'b0);
         total++; if (req_ready !== 1'b0)    begin bad++; $display("FAIL bp_req_ready c=%0d got=%b exp=0", c, req_ready); end
         total++; if (M1_out_ready !== 1'b0) begin bad++; $display("FAIL bp_m1_out_ready c=%0d got=%b exp=0", c, M1_out_ready); end
         total++; if (res_tag !== 5'd8)      begin bad++; $display("FAIL bp_res_tag c=%0d got=%0d exp=8", c, res_tag); end
         total++; if (res_sel_hi !== 1'b1)   begin bad++; $display("FAIL bp_sel_hi c=%0d got=%b exp=1", c, res_sel_hi); end
         tick();
      end
      exp_stall += 3;
      total++; if (stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
      total++; if (res_valid !== 1'b1 || res_tag !== 5'd8) begin bad++; $display("FAIL bp_rel1 got=%b/%0d exp=1/8", res_valid, res_tag); end
      tick();
      #1;
      total++; if (res_valid !== 1'b1 || res_tag !== 5'd9 || res_sel_hi !== 1'b0) begin
         bad++; $display("FAIL bp_rel2 got=%b/%0d/%b exp=1/9/0", res_valid, res_tag, res_sel_hi);
      end
      tick();
      exp_done += 2;
      #1;
      total++; if (done_cnt !== 32'(exp_done)) begin bad++; $display("FAIL bp_done_cnt got=%0d exp=%0d", done_cnt, exp_done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b exp=0", busy); end
   endtask

   task automatic test_flush();
      drive(1'b1, 2'b00, 5'd6, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b01, 5'd7, 1'b1, 1'b0);
      tick();
      // FULL: tag 6 in M2, tag 7 in M1; flush with a pending request.
      drive(1'b1, 2'b00, 5'd5, 1'b0, 1'b1);
      total++; if (res_tag !== 5'd6)      begin bad++; $display("FAIL fl_pre_tag got=%0d exp=6", res_tag); end
      total++; if (op_we !== 1'b0)        begin bad++; $display("FAIL fl_op_we got=%b exp=0", op_we); end
      total++; if (req_ready !== 1'b0)    begin bad++; $display("FAIL fl_req_ready got=%b exp=0", req_ready); end
      total++; if (M1_ready_go !== 1'b0)  begin bad++; $display("FAIL fl_m1_ready_go got=%b exp=0", M1_ready_go); end
      tick();
      exp_stall += 1;
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
      total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL fl_after got=%b/%b exp=0/0", busy, res_valid); end
      total++; if (done_cnt !== 32'(exp_done)) begin bad++; $display("FAIL fl_done_cnt got=%0d exp=%0d", done_cnt, exp_done); end
      total++; if (stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL fl_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
      // A handoff in the flush cycle still counts.
      drive(1'b1, 2'b00, 5'd14, 1'b0, 1'b0);
      tick();
      drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 2'b00, '0, 1'b1, 1'b1);
      total++; if (res_valid !== 1'b1 || res_tag !== 5'd14) begin bad++; $display("FAIL fl_m2only got=%b/%0d exp=1/14", res_valid, res_tag); end
      tick();
      exp_done += 1;
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
      total++; if (done_cnt !== 32'(exp_done)) begin bad++; $display("FAIL fl_handoff_cnt got=%0d exp=%0d", done_cnt, exp_done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL fl_handoff_busy got=%b exp=0", busy); end
   endtask

   task automatic test_simultaneous();
      drive(1'b1, 2'b01, 5'd11, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b10, 5'd12, 1'b0, 1'b0);
      tick();
      // FULL: 11 in M2, 12 (mulh.wu) in M1; drain and refill together.
      drive(1'b1, 2'b00, 5'd13, 1'b1, 1'b0);
      total++; if (m1_signed !== 1'b0) begin bad++; $display("FAIL sim_m1_signed_wu got=%b exp=0", m1_signed); end
      total++; if (M1_ready_go !== 1'b1 || M1_out_ready !== 1'b1) begin
         bad++; $display("FAIL sim_adv got=%b/%b exp=1/1", M1_ready_go, M1_out_ready);
      end
      total++; if (op_we !== 1'b1) begin bad++; $display("FAIL sim_op_we got=%b exp=1", op_we); end
      total++; if (res_tag !== 5'd11 || res_sel_hi !== 1'b1) begin bad++; $display("FAIL sim_res0 got=%0d/%b exp=11/1", res_tag, res_sel_hi); end
      tick();
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
      total++; if (busy !== 1'b1 || res_valid !== 1'b1 || M1_ready_go !== 1'b1) begin
         bad++; $display("FAIL sim_full got=%b/%b/%b exp=1/1/1", busy, res_valid, M1_ready_go);
      end
      total++; if (res_tag !== 5'd12 || res_sel_hi !== 1'b1) begin bad++; $display("FAIL sim_res1 got=%0d/%b exp=12/1", res_tag, res_sel_hi); end
      total++; if (m1_signed !== 1'b1) begin bad++; $display("FAIL sim_m1_signed_w got=%b exp=1", m1_signed); end
      tick();
      #1;
      total++; if (res_valid !== 1'b1 || res_tag !== 5'd13 || res_sel_hi !== 1'b0) begin
         bad++; $display("FAIL sim_res2 got=%b/%0d/%b exp=1/13/0", res_valid, res_tag, res_sel_hi);
      end
      tick();
      exp_done += 3;
      #1;
      total++; if (done_cnt !== 32'(exp_done)) begin bad++; $display("FAIL sim_done_cnt got=%0d exp=%0d", done_cnt, exp_done); end
   endtask

   task automatic test_signedness();
      drive(1'b1, 2'b11, 5'd3, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b01, 5'd17, 1'b1, 1'b0);
      total++; if (m1_signed !== 1'b1) begin bad++; $display("FAIL sgn_rsvd_m1 got=%b exp=1", m1_signed); end
      tick();
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
      total++; if (res_valid !== 1'b1 || res_tag !== 5'd3 || res_sel_hi !== 1'b0) begin
         bad++; $display("FAIL sgn_rsvd_res got=%b/%0d/%b exp=1/3/0", res_valid, res_tag, res_sel_hi);
      end
      total++; if (m1_signed !== 1'b1) begin bad++; $display("FAIL sgn_mulh_m1 got=%b exp=1", m1_signed); end
      tick();
      #1;
      total++; if (res_tag !== 5'd17 || res_sel_hi !== 1'b1) begin bad++; $display("FAIL sgn_mulh_res got=%0d/%b exp=17/1", res_tag, res_sel_hi); end
      tick();
      exp_done += 2;
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 2'b01, 5'd20, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b01, 5'd19, 1'b0, 1'b0);
      tick();
      drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
      total++; if (busy !== 1'b1 || done_cnt !== 32'(exp_done)) begin
         bad++; $display("FAIL rm_pre got=%b/%0d exp=1/%0d", busy, done_cnt, exp_done);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      exp_done  = 0;
      exp_stall = 0;
      total++; if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL rm_state got=%b/%b/%b exp=0/0/1", busy, res_valid, req_ready);
      end
      total++; if (res_tag !== 5'd0 || res_sel_hi !== 1'b0 || m1_signed !== 1'b1) begin
         bad++; $display("FAIL rm_data got=%0d/%b/%b exp=0/0/1", res_tag, res_sel_hi, m1_signed);
      end
      total++; if (done_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
         bad++; $display("FAIL rm_cnt got=%0d/%0d exp=0/0", done_cnt, stall_cnt);
      end
      total++; if (M1_out_ready !== 1'b1 || M1_ready_go !== 1'b0) begin
         bad++; $display("FAIL rm_hs got=%b/%b exp=1/0", M1_out_ready, M1_ready_go);
      end
      drive(1'b1, 2'b01, 5'd21, 1'b1, 1'b0);
      tick();
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rm_early got=%b exp=0", res_valid); end
      tick();
      #1;
      total++; if (res_valid !== 1'b1 || res_tag !== 5'd21 || res_sel_hi !== 1'b1) begin
         bad++; $display("FAIL rm_first got=%b/%0d/%b exp=1/21/1", res_valid, res_tag, res_sel_hi);
      end
      tick();
      exp_done += 1;
      #1;
      total++; if (done_cnt !== 32'(exp_done)) begin bad++; $display("FAIL rm_done_cnt got=%0d exp=%0d", done_cnt, exp_done); end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_tag   = '0;
      res_ready = 1'b0;
      flush     = 1'b0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_simultaneous();
      test_signedness();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
